score_event_unit: RTL and testbench

//   Multi-channel successor to the single-wire score-increment handshake between game logic and the processor.

---
 rtl/score_evt_pkg.sv | 35 +++
 rtl/score_event_unit_rr_arbiter.sv | 32 +++
 rtl/score_event_unit.sv | 176 +++++++++++++++++
 tb/tb_score_event_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_evt_pkg.sv
// Shared types and helpers for the score event unit.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package score_evt_pkg;

    // Handshake sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    // Widest score register the saturation helper handles
    localparam int SAT_MAX_W = 64;

    // Channel id width: at least one bit even for a single channel
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Unsigned add that clamps to the all-ones value of a w-bit register
    function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                     input logic [SAT_MAX_W-1:0] b,
                                                     input int                   w);
        logic [SAT_MAX_W:0]   sum;
        logic [SAT_MAX_W-1:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/score_event_unit_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr wins, wrapping at N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant simply follows the request vector.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    // Scan N positions starting at ptr; the first hit is the winner
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = IW'(idx);
                gnt[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_event_unit.sv
// Per-channel scoring event queue, round-robin req/ack server and saturating score register.
// Latency: event pulse to inc_req is 2 cycles when idle; score updates on the accepting ack edge.
// Backpressure: inc_ack throttles service; counters saturate and flag overflow. SCORE_EVT_TIMEOUT_EN adds an ack timeout.
module score_event_unit
    import score_evt_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int SCORE_W     = 32,
    parameter  int PTS_W       = 8,
    parameter  int CNT_W       = 4,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int CH_W        = ch_w(N_CH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_CH-1:0]       event_in,
    input  logic [N_CH*PTS_W-1:0] ch_points,
    input  logic                  clear_score,
    output logic                  inc_req,
    output logic [CH_W-1:0]       inc_ch,
    output logic [PTS_W-1:0]      inc_points,
    input  logic                  inc_ack,
    output logic [SCORE_W-1:0]    score,
    output logic                  pending_any,
    output logic [N_CH-1:0]       overflow,
    output logic                  timeout_err
);

    // Elaboration guard on parameter ranges
    if (N_CH < 2 || N_CH > 16 || TIMEOUT_CYC < 1 || SCORE_W > SAT_MAX_W) begin : g_param_check
        $error("score_event_unit: parameter out of range");
    end

    state_t             state;
    logic [CH_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt [N_CH];
    logic [N_CH-1:0]    pend;
    logic [N_CH-1:0]    full;
    logic [N_CH-1:0]    dec;
    logic [N_CH-1:0]    arb_gnt;
    logic [CH_W-1:0]    arb_idx;
    logic               arb_vld;
    logic [PTS_W-1:0]   arb_pts;
    logic [CH_W-1:0]    ptr_nxt;
    logic [SCORE_W-1:0] score_base;
    logic [SCORE_W-1:0] score_add;

    // Per-channel status and the decrement strobe for the channel being acked
    always_comb begin
        pend = '0;
        full = '0;
        dec  = '0;
        for (int i = 0; i < N_CH; i++) begin
            pend[i] = |cnt[i];
            full[i] = &cnt[i];
            dec[i]  = (state == ST_REQ) && inc_ack && (inc_ch == CH_W'(i));
        end
    end

    assign pending_any = |pend;

    rr_arbiter #(
        .N  (N_CH),
        .IW (CH_W)
    ) u_arb (
        .req     (pend),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // One-hot AND-OR select of the winning channel's points
    always_comb begin
        arb_pts = '0;
        for (int i = 0; i < N_CH; i++) begin
            arb_pts = arb_pts | (arb_gnt[i] ? ch_points[i*PTS_W +: PTS_W] : '0);
        end
    end

    // Rotation pointer and score arithmetic; a coincident clear zeroes the base before the add
    always_comb begin
        ptr_nxt    = (inc_ch == CH_W'(N_CH - 1)) ? '0 : inc_ch + 1'b1;
        score_base = clear_score ? '0 : score;
        score_add  = SCORE_W'(sat_add(SAT_MAX_W'(score_base), SAT_MAX_W'(inc_points), SCORE_W));
    end

    // Pending counters: event increments, accepted ack decrements, both together cancel.
    // A full counter drops the event and flags overflow; if the same edge also frees a slot the event is kept.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt      <= '{default: '0};
            overflow <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (event_in[i] && !dec[i]) begin
                    if (!full[i]) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end else begin
                        overflow[i] <= 1'b1;
                    end
                end else if (!event_in[i] && dec[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

`ifdef SCORE_EVT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_r;
    assign timeout_err = timeout_r;
`else
    assign timeout_err = 1'b0;
`endif

    // Handshake sequencer with registered request outputs and the score register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            inc_req    <= 1'b0;
            inc_ch     <= '0;
            inc_points <= '0;
            ptr        <= '0;
            score      <= '0;
`ifdef SCORE_EVT_TIMEOUT_EN
            tmo_cnt    <= '0;
            timeout_r  <= 1'b0;
`endif
        end else begin
            if (clear_score) begin
                score <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        inc_ch     <= arb_idx;
                        inc_points <= arb_pts;
                        inc_req    <= 1'b1;
                        state      <= ST_REQ;
`ifdef SCORE_EVT_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (inc_ack) begin
                        score   <= score_add;
                        ptr     <= ptr_nxt;
                        inc_req <= 1'b0;
                        state   <= ST_REL;
                    end
`ifdef SCORE_EVT_TIMEOUT_EN
                    // Abandon the request; the counter is untouched so the event is retried
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        inc_req   <= 1'b0;
                        timeout_r <= 1'b1;
                        ptr       <= ptr_nxt;
                        state     <= ST_REL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_REL: begin
                    if (!inc_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_event_unit.sv
// Directed bench for score_event_unit: latency, rotation, overflow, saturation, clear, reset and timeout.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench plays the processor side of the req/ack handshake.
module tb_score_event_unit;

    logic        clock;
    logic        reset;
    logic [3:0]  event_in;
    logic [31:0] ch_points;
    logic        clear_score;
    logic        inc_req;
    logic [1:0]  inc_ch;
    logic [7:0]  inc_points;
    logic        inc_ack;
    logic [15:0] score;
    logic        pending_any;
    logic [3:0]  overflow;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    score_event_unit #(
        .N_CH        (4),
        .SCORE_W     (16),
        .PTS_W       (8),
        .CNT_W       (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .event_in    (event_in),
        .ch_points   (ch_points),
        .clear_score (clear_score),
        .inc_req     (inc_req),
        .inc_ch      (inc_ch),
        .inc_points  (inc_points),
        .inc_ack     (inc_ack),
        .score       (score),
        .pending_any (pending_any),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] ev);
        event_in = ev;
        tick();
        event_in = 4'd0;
    endtask

    task automatic wait_req();
        for (int k = 0; k < 20 && !inc_req; k++) tick();
        check("req_wait", 64'(inc_req), 64'd1);
    endtask

    // Wait for a request, check it, then ack for one cycle and release
    task automatic serve(input logic [1:0] exp_ch, input logic [7:0] exp_pts);
        wait_req();
        check("serve_ch", 64'(inc_ch), 64'(exp_ch));
        check("serve_pts", 64'(inc_points), 64'(exp_pts));
        inc_ack = 1'b1;
        tick();
        check("serve_drop", 64'(inc_req), 64'd0);
        inc_ack = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        event_in    = 4'd0;
        ch_points   = {8'd9, 8'd5, 8'd7, 8'd3};
        clear_score = 1'b0;
        inc_ack     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req", 64'(inc_req), 64'd0);
        check("rst_ch", 64'(inc_ch), 64'd0);
        check("rst_pts", 64'(inc_points), 64'd0);
        check("rst_score", 64'(score), 64'd0);
        check("rst_pend", 64'(pending_any), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_tmo", 64'(timeout_err), 64'd0);
        reset = 1'b1;
        tick();

        // Single event on ch2: req two edges after the pulse, ack three cycles later
        pulse(4'b0100);
        check("t1_req_c1", 64'(inc_req), 64'd0);
        check("t1_pend", 64'(pending_any), 64'd1);
        tick();
        check("t1_req_c2", 64'(inc_req), 64'd1);
        check("t1_ch", 64'(inc_ch), 64'd2);
        check("t1_pts", 64'(inc_points), 64'd5);
        tick();
        tick();
        check("t1_hold", 64'(inc_req), 64'd1);
        inc_ack = 1'b1;
        tick();
        check("t1_score", 64'(score), 64'd5);
        check("t1_drop", 64'(inc_req), 64'd0);
        check("t1_pend0", 64'(pending_any), 64'd0);
        tick();
        check("t1_rel_hold", 64'(inc_req), 64'd0);
        inc_ack = 1'b0;
        tick();

        // Burst on 0,1,3 from ptr=0, then ch0 alone, then 0,1 grants 1 before 0
        do_reset();
        pulse(4'b1011);
        serve(2'd0, 8'd3);
        serve(2'd1, 8'd7);
        serve(2'd3, 8'd9);
        pulse(4'b0001);
        serve(2'd0, 8'd3);
        pulse(4'b0011);
        serve(2'd1, 8'd7);
        serve(2'd0, 8'd3);
        check("t2_score", 64'(score), 64'd32);
        check("t2_pend", 64'(pending_any), 64'd0);

        // 16 pulses on ch1 with no ack: 15 queued, overflow set
        do_reset();
        event_in = 4'b0010;
        for (int i = 0; i < 16; i++) tick();
        event_in = 4'd0;
        check("t3_ovf", 64'(overflow), 64'h2);
        for (int i = 0; i < 14; i++) serve(2'd1, 8'd7);
        check("t3_pend14", 64'(pending_any), 64'd1);
        serve(2'd1, 8'd7);
        check("t3_pend15", 64'(pending_any), 64'd0);
        check("t3_score", 64'(score), 64'd105);
        check("t3_ovf_sticky", 64'(overflow), 64'h2);
        tick();
        tick();
        check("t3_no16th", 64'(inc_req), 64'd0);

        // Drive score to 0xFFF0, then saturate with 0x20
        do_reset();
        ch_points[31:24] = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            pulse(4'b1000);
            serve(2'd3, 8'hFF);
        end
        ch_points[31:24] = 8'd240;
        pulse(4'b1000);
        serve(2'd3, 8'd240);
        check("t4_near", 64'(score), 64'hFFF0);
        ch_points[31:24] = 8'h20;
        pulse(4'b1000);
        serve(2'd3, 8'h20);
        check("t4_sat", 64'(score), 64'hFFFF);
        ch_points[7:0] = 8'd0;
        pulse(4'b0001);
        serve(2'd0, 8'd0);
        check("t4_zero_pts", 64'(score), 64'hFFFF);
        check("t4_pend", 64'(pending_any), 64'd0);

        // Clear coinciding with an accepting ack, then a plain clear
        pulse(4'b0100);
        wait_req();
        clear_score = 1'b1;
        inc_ack     = 1'b1;
        tick();
        clear_score = 1'b0;
        check("t5_clr_ack", 64'(score), 64'd5);
        inc_ack = 1'b0;
        tick();
        clear_score = 1'b1;
        tick();
        clear_score = 1'b0;
        check("t5_clr", 64'(score), 64'd0);

        // Event and ack on the same channel in one cycle leave the count at 2
        event_in = 4'b0010;
        tick();
        tick();
        event_in = 4'd0;
        wait_req();
        check("t6_ch", 64'(inc_ch), 64'd1);
        event_in = 4'b0010;
        inc_ack  = 1'b1;
        tick();
        event_in = 4'd0;
        inc_ack  = 1'b0;
        tick();
        serve(2'd1, 8'd7);
        check("t6_pend1", 64'(pending_any), 64'd1);
        serve(2'd1, 8'd7);
        check("t6_pend0", 64'(pending_any), 64'd0);
        check("t6_score", 64'(score), 64'd21);
        tick();
        tick();
        check("t6_idle", 64'(inc_req), 64'd0);

        // Reset asserted during REQ
        pulse(4'b0001);
        wait_req();
        reset = 1'b0;
        tick();
        check("t7_req", 64'(inc_req), 64'd0);
        check("t7_score", 64'(score), 64'd0);
        check("t7_pend", 64'(pending_any), 64'd0);
        reset = 1'b1;
        tick();

`ifdef SCORE_EVT_TIMEOUT_EN
        // No ack: request held exactly 8 cycles, then dropped and retried
        pulse(4'b0100);
        wait_req();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t8_held", 64'(inc_req), 64'd1);
        end
        tick();
        check("t8_drop", 64'(inc_req), 64'd0);
        check("t8_err", 64'(timeout_err), 64'd1);
        check("t8_pend", 64'(pending_any), 64'd1);
        serve(2'd2, 8'd5);
        check("t8_pend0", 64'(pending_any), 64'd0);
        check("t8_score", 64'(score), 64'd5);
`else
        // Without the timeout build the request waits and the flag stays low
        pulse(4'b0100);
        wait_req();
        for (int i = 0; i < 20; i++) tick();
        check("t8_wait", 64'(inc_req), 64'd1);
        check("t8_no_err", 64'(timeout_err), 64'd0);
        serve(2'd2, 8'd5);
        check("t8_score", 64'(score), 64'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
